tmr_regfile_scrub: RTL and testbench

- Triplicated register file: DEPTH entries of W bits, three replicas per entry, majority-voted read port.
- A background scrubber FSM walks all entries and rewrites any diverged replica. Scrubbing happens without needing a quiet write port.
- Adds fault-injection, error reporting and a saturating correction counter for radiation-test and BIST use.
- Sits beside the existing single-word TMR register as the storage for multi-word configuration/state banks.

---
 rtl/tmr_regfile_scrub_pkg.sv | 20 ++
 rtl/tmr_regfile_scrub_voter3.sv | 17 +
 rtl/tmr_regfile_scrub.sv | 130 +++++++++++++
 tb/tb_tmr_regfile_scrub.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_regfile_scrub_pkg.sv
// Shared types and constants for the triplicated, scrubbed register file.
package tmr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FIX
  } scrub_state_e;

  localparam logic [1:0] REP0     = 2'd0;
  localparam logic [1:0] REP1     = 2'd1;
  localparam logic [1:0] REP2     = 2'd2;
  localparam logic [1:0] REP_NONE = 2'd3;

  // True when at least two of the three replicas disagree with the vote.
  function automatic logic multi_dev(input logic [2:0] dev);
    return (dev[0] & dev[1]) | (dev[0] & dev[2]) | (dev[1] & dev[2]);
  endfunction

endpackage

// File: rtl/tmr_regfile_scrub_voter3.sv
// W-bit bitwise 2-of-3 majority voter with per-replica deviation flags.
module voter3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y,
  output logic [2:0]   dev
);

  always_comb begin
    y   = (a & b) | (a & c) | (b & c);
    dev = {c != y, b != y, a != y};
  end

endmodule

// File: rtl/tmr_regfile_scrub.sv
// Triplicated register file with voted read port, fault injection and a
// background scrubber that rewrites diverged replicas.
module tmr_regfile_scrub
  import tmr_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [W-1:0]     wdata,
  input  logic [AW-1:0]    raddr,
  output logic [W-1:0]     rdata,
  output logic             rd_err,
  input  logic             scrub_en,
  output logic             scrub_busy,
  output logic             pass_done,
  output logic             multi_err,
  output logic [CNT_W-1:0] corr_cnt,
  input  logic             clr_stats,
  input  logic             inj_en,
  input  logic [AW-1:0]    inj_addr,
  input  logic [1:0]       inj_rep,
  input  logic [W-1:0]     inj_mask
);

  logic [W-1:0] rep [3][DEPTH];

  scrub_state_e state;
  logic [AW-1:0] scrub_ptr;
  logic [W-1:0]  fix_val;
  logic          fix_multi;

  logic [W-1:0] rd_r0, rd_r1, rd_r2, sc_r0, sc_r1, sc_r2;
  logic [W-1:0] scr_voted;
  logic [2:0]   scr_dev, rd_dev;
  logic         inj_valid, ptr_hit, fix_commit, advance, ptr_last;

  assign rd_r0 = rep[0][raddr];
  assign rd_r1 = rep[1][raddr];
  assign rd_r2 = rep[2][raddr];
  assign sc_r0 = rep[0][scrub_ptr];
  assign sc_r1 = rep[1][scrub_ptr];
  assign sc_r2 = rep[2][scrub_ptr];

  voter3 #(.W(W)) u_rd_vote (.a(rd_r0), .b(rd_r1), .c(rd_r2), .y(rdata), .dev(rd_dev));
  voter3 #(.W(W)) u_sc_vote (.a(sc_r0), .b(sc_r1), .c(sc_r2), .y(scr_voted), .dev(scr_dev));

  assign rd_err     = |rd_dev;
  assign scrub_busy = (state != IDLE);

  always_comb begin
    inj_valid  = inj_en && (inj_rep != REP_NONE);
    ptr_hit    = (we && waddr == scrub_ptr) || (inj_valid && inj_addr == scrub_ptr);
    fix_commit = (state == FIX) && !ptr_hit;
    advance    = ((state == SCAN) && !(|scr_dev)) || fix_commit;
    ptr_last   = (scrub_ptr == AW'(DEPTH - 1));
  end

  // Later assignments override earlier ones: write > inject > scrub fix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 3; k++)
        for (int unsigned i = 0; i < DEPTH; i++)
          rep[k][i] <= '0;
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (fix_commit) rep[k][scrub_ptr] <= fix_val;
        if (inj_valid && inj_rep == 2'(k)) rep[k][inj_addr] <= rep[k][inj_addr] ^ inj_mask;
        if (we) rep[k][waddr] <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      scrub_ptr <= '0;
      fix_val   <= '0;
      fix_multi <= 1'b0;
      pass_done <= 1'b0;
      corr_cnt  <= '0;
      multi_err <= 1'b0;
    end else begin
      pass_done <= 1'b0;
      case (state)
        IDLE: begin
          if (scrub_en) begin
            state     <= SCAN;
            scrub_ptr <= '0;
          end
        end
        // A dirty entry touched by a write/inject this cycle is re-voted
        // next cycle so a stale latched value never overwrites new data.
        SCAN: begin
          if ((|scr_dev) && !ptr_hit) begin
            state     <= FIX;
            fix_val   <= scr_voted;
            fix_multi <= multi_dev(scr_dev);
          end
        end
        FIX:     state <= SCAN;
        default: state <= IDLE;
      endcase

      if (advance) begin
        if (ptr_last) begin
          scrub_ptr <= '0;
          pass_done <= 1'b1;
          state     <= scrub_en ? SCAN : IDLE;
        end else begin
          scrub_ptr <= scrub_ptr + AW'(1);
        end
      end

      if (clr_stats) begin
        corr_cnt  <= '0;
        multi_err <= 1'b0;
      end else if (fix_commit) begin
        if (corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
        if (fix_multi) multi_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tmr_regfile_scrub.sv
// Self-checking bench: directed vector table, scrub corner sequences and
// randomized traffic against a replica-array reference model.
module tb_tmr_regfile_scrub;
  localparam int W = 8, DEPTH = 16, CNT_W = 8, AW = 4;
  localparam int D2 = 4, AW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, we, rd_err, scrub_en, scrub_busy, pass_done, multi_err, clr_stats, inj_en;
  logic [AW-1:0] waddr, raddr, inj_addr;
  logic [W-1:0] wdata, rdata, inj_mask;
  logic [1:0] inj_rep;
  logic [CNT_W-1:0] corr_cnt;

  logic s_we, s_rd_err, s_scrub_en, s_busy, s_pass_done, s_multi_err, s_clr, s_inj_en;
  logic [AW2-1:0] s_waddr, s_raddr, s_inj_addr;
  logic [W-1:0] s_wdata, s_rdata, s_inj_mask;
  logic [1:0] s_inj_rep, s_corr_cnt;

  tmr_regfile_scrub #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata), .rd_err(rd_err), .scrub_en(scrub_en), .scrub_busy(scrub_busy),
    .pass_done(pass_done), .multi_err(multi_err), .corr_cnt(corr_cnt), .clr_stats(clr_stats),
    .inj_en(inj_en), .inj_addr(inj_addr), .inj_rep(inj_rep), .inj_mask(inj_mask));

  tmr_regfile_scrub #(.W(W), .DEPTH(D2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .we(s_we), .waddr(s_waddr), .wdata(s_wdata), .raddr(s_raddr),
    .rdata(s_rdata), .rd_err(s_rd_err), .scrub_en(s_scrub_en), .scrub_busy(s_busy),
    .pass_done(s_pass_done), .multi_err(s_multi_err), .corr_cnt(s_corr_cnt), .clr_stats(s_clr),
    .inj_en(s_inj_en), .inj_addr(s_inj_addr), .inj_rep(s_inj_rep), .inj_mask(s_inj_mask));

  typedef struct {
    bit we; int waddr; logic [W-1:0] wdata;
    bit inj_en; int inj_addr; int inj_rep; logic [W-1:0] inj_mask;
    int raddr; logic [W-1:0] exp_rdata; bit exp_err;
  } vec_t;
  vec_t tbl[9];

  int nvec = 0, nerr = 0;
  logic [W-1:0] m [3][DEPTH];
  int exp_cnt = 0;
  bit exp_multi = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mvote(input int a);
    logic [W-1:0] v;
    int ones;
    for (int b = 0; b < W; b++) begin
      ones = int'(m[0][a][b]) + int'(m[1][a][b]) + int'(m[2][a][b]);
      v[b] = (ones >= 2);
    end
    return v;
  endfunction

  function automatic int ndev(input int a);
    int n = 0;
    for (int k = 0; k < 3; k++) if (m[k][a] != mvote(a)) n++;
    return n;
  endfunction

  task automatic model_clear;
    for (int k = 0; k < 3; k++) for (int a = 0; a < DEPTH; a++) m[k][a] = '0;
    exp_cnt = 0;
    exp_multi = 0;
  endtask

  task automatic drive(input bit w, input int wa, input logic [W-1:0] wd,
                       input bit ie, input int ia, input int ir, input logic [W-1:0] im);
    we = w; waddr = AW'(wa); wdata = wd;
    inj_en = ie; inj_addr = AW'(ia); inj_rep = 2'(ir); inj_mask = im;
    if (ie && ir < 3 && !(w && wa == ia)) m[ir][ia] = m[ir][ia] ^ im;
    if (w) for (int k = 0; k < 3; k++) m[k][wa] = wd;
    tick();
    we = 0; inj_en = 0;
  endtask

  task automatic check_entry(input int a);
    raddr = AW'(a);
    #1;
    check($sformatf("rdata[%0d]", a), 32'(rdata), 32'(mvote(a)));
    check($sformatf("rd_err[%0d]", a), 32'(rd_err), 32'(ndev(a) != 0));
  endtask

  task automatic wait_pass(input string name, inout int cycles, input int limit);
    while (!pass_done && cycles < limit) begin
      tick();
      cycles++;
    end
    if (!pass_done) begin
      nerr++;
      $display("FAIL %s: pass_done timeout after %0d cycles", name, cycles);
    end
  endtask

  // One single-shot pass; expectations derived from the model's dirty set.
  task automatic run_pass(input string name);
    int nd = 0, cycles = 0;
    bit mul = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (ndev(a) > 0) nd++;
      if (ndev(a) >= 2) mul = 1;
    end
    scrub_en = 1; tick(); scrub_en = 0;
    check({name, "_busy"}, 32'(scrub_busy), 1);
    wait_pass(name, cycles, 200);
    check({name, "_len"}, cycles, DEPTH + nd);
    check({name, "_idle"}, 32'(scrub_busy), 0);
    exp_cnt = (exp_cnt + nd > 255) ? 255 : exp_cnt + nd;
    exp_multi = exp_multi | mul;
    check({name, "_corr"}, 32'(corr_cnt), exp_cnt);
    check({name, "_multi"}, 32'(multi_err), 32'(exp_multi));
    for (int a = 0; a < DEPTH; a++) begin
      logic [W-1:0] v;
      v = mvote(a);
      for (int k = 0; k < 3; k++) m[k][a] = v;
    end
    for (int a = 0; a < DEPTH; a++) check_entry(a);
  endtask

  task automatic apply_vec(input vec_t v);
    drive(v.we, v.waddr, v.wdata, v.inj_en, v.inj_addr, v.inj_rep, v.inj_mask);
    raddr = AW'(v.raddr);
    #1;
    check("vec_rdata", 32'(rdata), 32'(v.exp_rdata));
    check("vec_rd_err", 32'(rd_err), 32'(v.exp_err));
  endtask

  initial begin
    int cycles;
    tbl[0] = '{1, 3, 8'hA5, 0, 0, 0, 8'h00, 3, 8'hA5, 0};
    tbl[1] = '{1, 5, 8'h3C, 0, 0, 0, 8'h00, 5, 8'h3C, 0};
    tbl[2] = '{0, 0, 8'h00, 1, 5, 1, 8'h81, 5, 8'h3C, 1};
    tbl[3] = '{0, 0, 8'h00, 1, 7, 0, 8'h01, 7, 8'h00, 1};
    tbl[4] = '{0, 0, 8'h00, 1, 7, 2, 8'h02, 7, 8'h00, 1};
    tbl[5] = '{0, 0, 8'h00, 1, 2, 3, 8'hFF, 2, 8'h00, 0};
    tbl[6] = '{1, 4, 8'h11, 1, 4, 0, 8'hFF, 4, 8'h11, 0};
    tbl[7] = '{1, 6, 8'h22, 1, 8, 0, 8'hF0, 8, 8'h00, 1};
    tbl[8] = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 6, 8'h22, 0};

    rst_n = 0; we = 0; waddr = '0; wdata = '0; raddr = '0; scrub_en = 0; clr_stats = 0;
    inj_en = 0; inj_addr = '0; inj_rep = '0; inj_mask = '0;
    s_we = 0; s_waddr = '0; s_wdata = '0; s_raddr = '0; s_scrub_en = 0; s_clr = 0;
    s_inj_en = 0; s_inj_addr = '0; s_inj_rep = '0; s_inj_mask = '0;
    model_clear();
    tick(); tick();
    rst_n = 1;
    tick();
    check("rst_corr", 32'(corr_cnt), 0);
    check("rst_busy", 32'(scrub_busy), 0);
    check("rst_pass", 32'(pass_done), 0);
    check("rst_multi", 32'(multi_err), 0);
    check_entry(3);

    for (int i = 0; i < 3; i++) apply_vec(tbl[i]);
    run_pass("pass_single");
    for (int i = 3; i < 9; i++) apply_vec(tbl[i]);
    run_pass("pass_multi");
    clr_stats = 1; tick(); clr_stats = 0;
    exp_cnt = 0; exp_multi = 0;
    check("clr_corr", 32'(corr_cnt), 0);
    check("clr_multi", 32'(multi_err), 0);

    // Write collides with the FIX of entry 9: fix dropped, entry rescanned.
    drive(0, 0, '0, 1, 9, 2, 8'h0F);
    scrub_en = 1; tick(); scrub_en = 0;
    repeat (10) tick();
    check("cancel_busy", 32'(scrub_busy), 1);
    drive(1, 9, 8'h55, 0, 0, 0, '0);
    cycles = 11;
    wait_pass("cancel", cycles, 200);
    check("cancel_len", cycles, DEPTH + 2);
    check("cancel_corr", 32'(corr_cnt), 0);
    for (int a = 0; a < DEPTH; a++) check_entry(a);

    // clr_stats in the same cycle as a committing FIX.
    drive(0, 0, '0, 1, 0, 1, 8'h10);
    scrub_en = 1; tick(); scrub_en = 0;
    tick();
    clr_stats = 1; tick(); clr_stats = 0;
    check("clrfix_corr", 32'(corr_cnt), 0);
    cycles = 2;
    wait_pass("clrfix", cycles, 200);
    for (int k = 0; k < 3; k++) m[k][0] = mvote(0);
    check_entry(0);
    check("clrfix_corr2", 32'(corr_cnt), 0);

    // Continuous scrubbing, then stop requested while scanning entry 4.
    scrub_en = 1; tick();
    cycles = 0; wait_pass("cont1", cycles, 200); check("cont1_len", cycles, DEPTH);
    cycles = 0; tick(); cycles++; wait_pass("cont2", cycles, 200); check("cont2_len", cycles, DEPTH);
    repeat (4) tick();
    scrub_en = 0; tick();
    cycles = 5;
    wait_pass("stop", cycles, 200);
    check("stop_len", cycles, DEPTH);
    check("stop_idle", 32'(scrub_busy), 0);
    check("cont_corr", 32'(corr_cnt), 0);

    // Reset asserted while the FSM sits in FIX.
    drive(1, 1, 8'h77, 0, 0, 0, '0);
    drive(0, 0, '0, 1, 2, 0, 8'h01);
    scrub_en = 1; tick(); scrub_en = 0;
    repeat (3) tick();
    check("prerst_busy", 32'(scrub_busy), 1);
    rst_n = 0;
    #1;
    model_clear();
    check("midrst_busy", 32'(scrub_busy), 0);
    check("midrst_corr", 32'(corr_cnt), 0);
    for (int a = 0; a < DEPTH; a++) check_entry(a);
    @(negedge clk); rst_n = 1;
    tick();

    // Randomized traffic with scrub off, then a verifying pass.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 120; c++) begin
        drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, DEPTH - 1)), W'($urandom),
              ($urandom_range(0, 2) == 0), int'($urandom_range(0, DEPTH - 1)),
              int'($urandom_range(0, 3)), W'($urandom));
        check_entry(int'($urandom_range(0, DEPTH - 1)));
      end
      run_pass("rand_pass");
    end

    // Saturation on a CNT_W=2 instance.
    for (int k = 0; k < 5; k++) begin
      s_inj_en = 1; s_inj_addr = AW2'(k % D2); s_inj_rep = 2'd0; s_inj_mask = 8'h01;
      tick(); s_inj_en = 0;
      s_scrub_en = 1; tick(); s_scrub_en = 0;
      cycles = 0;
      while (!s_pass_done && cycles < 50) begin tick(); cycles++; end
      check("sat_pass_seen", 32'(s_pass_done), 1);
      check("sat_corr", 32'(s_corr_cnt), (k + 1 > 3) ? 3 : k + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
